// File: rtl/accum_pkg.sv
// Shared types and helpers for the accum_group reducer.
package accum_pkg;

  typedef enum logic {
    S_FIRST,
    S_ACC
  } state_t;

  // Bits needed to hold a beat count of 1..count.
  function automatic int beats_w(input int count);
    return $clog2(count) + 1;
  endfunction

endpackage

// File: rtl/accum_add_sat.sv
// Combinational W-bit unsigned adder; 0 latency, no handshake.
// Wraps modulo 2^W, or clamps to all-ones on carry-out when ACCUM_GROUP_SATURATE_EN is defined.
module accum_add_sat #(
  parameter int W = 18
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum
);

`ifdef ACCUM_GROUP_SATURATE_EN
  logic [W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b};
  assign o_sum  = w_full[W] ? {W{1'b1}} : w_full[W-1:0];
`else
  assign o_sum = i_a + i_b;
`endif

endmodule

// File: rtl/accum_group.sv
// Sums groups of up to COUNT beats (early close on i_data_last); sum registered 1 cycle after closing beat.
// Input ready drops while a sum is held and not taken; ACCUM_GROUP_SATURATE_EN selects clamping adds.
module accum_group
  import accum_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int COUNT     = 4,
  parameter int SUM_WIDTH = 18
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        i_data_valid,
  output logic                        o_data_ready,
  input  logic [WIDTH-1:0]            i_data,
  input  logic                        i_data_last,
  output logic                        o_sum_valid,
  input  logic                        i_sum_ready,
  output logic [SUM_WIDTH-1:0]        o_sum,
  output logic [beats_w(COUNT)-1:0]   o_sum_beats
);

  localparam int            BW       = beats_w(COUNT);
  localparam logic [BW-1:0] LAST_CNT = BW'(COUNT - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SUM_WIDTH-1:0] r_acc;
  logic [SUM_WIDTH-1:0] w_acc_in;
  logic [SUM_WIDTH-1:0] w_beat;
  logic [SUM_WIDTH-1:0] w_add;
  logic [BW-1:0]        r_cnt;
  logic [BW-1:0]        w_cnt_in;
  logic                 w_accept;
  logic                 w_close;

  assign o_data_ready = !(o_sum_valid && !i_sum_ready);
  assign w_accept     = i_data_valid && o_data_ready;

  // S_FIRST treats the held partial as empty regardless of register contents.
  assign w_acc_in = (r_state == S_ACC) ? r_acc : '0;
  assign w_cnt_in = (r_state == S_ACC) ? r_cnt : '0;
  assign w_close  = w_accept && (i_data_last || (w_cnt_in == LAST_CNT));
  assign w_beat   = SUM_WIDTH'(i_data);

  accum_add_sat #(.W(SUM_WIDTH)) u_add (
    .i_a   (w_acc_in),
    .i_b   (w_beat),
    .o_sum (w_add)
  );

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_FIRST;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_close)       w_state_nxt = S_FIRST;
    else if (w_accept) w_state_nxt = S_ACC;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_close) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= w_add;
      r_cnt <= w_cnt_in + BW'(1);
    end
  end

  // A closing beat is only accepted when the register is empty or being drained.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      o_sum_valid <= 1'b0;
      o_sum       <= '0;
      o_sum_beats <= '0;
    end else if (w_close) begin
      o_sum_valid <= 1'b1;
      o_sum       <= w_add;
      o_sum_beats <= w_cnt_in + BW'(1);
    end else if (i_sum_ready) begin
      o_sum_valid <= 1'b0;
    end
  end

endmodule
